// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with its shared 4-bit alu)
// Brief    : Round-robin arbiter time-sharing one combinational ALU between
//            up to four requesters, with a single tagged response channel.
// Revision : 1.0 - initial release
// ============================================================================

module alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [3:0] result,
    output logic       carry_out,
    output logic       zero
);
    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic [3:0] w_neg_b;

    // Subtraction is a + two's-complement(b), so b=0 yields carry 0.
    assign w_neg_b = ~b + 4'd1;
    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} + {1'b0, w_neg_b};

    always_comb begin
        result    = 4'd0;
        carry_out = 1'b0;
        case (sel)
            2'b00: begin
                result    = w_sum[3:0];
                carry_out = w_sum[4];
            end
            2'b01: begin
                result    = w_diff[3:0];
                carry_out = w_diff[4];
            end
            2'b10:   result = a & b;
            default: result = a | b;
        endcase
    end

    assign zero = (result == 4'd0);
endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]   req_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [3:0]             rsp_result,
    output logic                   rsp_carry,
    output logic                   rsp_zero,
    output logic                   busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] c_last_init = 2'(NUM_REQ - 1);

    logic [1:0] r_state;
    logic [1:0] r_last_grant;
    logic [1:0] r_op_id;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [1:0] r_sel;

    logic [2:0] w_cand;
    logic [1:0] w_grant_idx;
    logic       w_grant_found;
    logic [3:0] w_a;
    logic [3:0] w_b;
    logic [1:0] w_sel;
    logic [3:0] w_alu_result;
    logic       w_alu_carry;
    logic       w_alu_zero;

    // Search upward from the requester after the last winner, wrapping.
    always_comb begin
        w_cand        = 3'd0;
        w_grant_idx   = r_last_grant;
        w_grant_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last_grant} + 3'(k);
            if (w_cand >= 3'(NUM_REQ)) begin
                w_cand = w_cand - 3'(NUM_REQ);
            end
            if (!w_grant_found && req_valid[w_cand[1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand[1:0];
            end
        end
    end

    always_comb begin
        w_a   = 4'd0;
        w_b   = 4'd0;
        w_sel = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == 2'(i)) begin
                w_a   = req_a[4*i +: 4];
                w_b   = req_b[4*i +: 4];
                w_sel = req_sel[2*i +: 2];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == IDLE) && w_grant_found) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    alu u_alu (
        .a         (r_a),
        .b         (r_b),
        .sel       (r_sel),
        .result    (w_alu_result),
        .carry_out (w_alu_carry),
        .zero      (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= c_last_init;
            r_op_id      <= 2'd0;
            r_a          <= 4'd0;
            r_b          <= 4'd0;
            r_sel        <= 2'd0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 2'd0;
            rsp_result   <= 4'd0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_found) begin
                        r_a          <= w_a;
                        r_b          <= w_b;
                        r_sel        <= w_sel;
                        r_op_id      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= w_alu_result;
                    rsp_carry  <= w_alu_carry;
                    rsp_zero   <= w_alu_zero;
                    rsp_id     <= r_op_id;
                    rsp_valid  <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that time-shares one 4-bit combinational `alu` (add/sub/and/or, `sel` 00/01/10/11) between up to four requesters. Each requester hands over one operation with a valid/ready handshake. The block registers the operands, drives the shared ALU, registers `result`, `carry_out` and `zero`, and returns them tagged with the requester id on a single response channel. It sits between the client blocks and the single `alu` instance, so it is the only driver of the ALU inputs.

## Interface
Parameters:
- `NUM_REQ`, default 4. Number of requesters, legal range 2..4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i set means requester i holds an operation.
- `req_ready`  out  NUM_REQ  one-hot grant/accept; bit i high means requester i's operation is taken this cycle.
- `req_a`  in  4*NUM_REQ  operand a; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NUM_REQ  operand b, same packing as `req_a`.
- `req_sel`  in  2*NUM_REQ  ALU op, bits [2i+1:2i].
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  2  index of the requester that owns the response.
- `rsp_result`  out  4  ALU result.
- `rsp_carry`  out  1  ALU `carry_out`.
- `rsp_zero`  out  1  ALU `zero`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any `req_valid` bit is set, pick the first set index searching upward (cyclically) from `last_grant+1`.
  - Assert `req_ready[g]` combinationally in that cycle only.
  - At the edge, latch `a`, `b`, `sel` and `id=g`, set `last_grant<=g`, and go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE with `req_ready` all zero.
- EXEC:
  - The ALU sees the latched operands.
  - At the edge, capture `result`, `carry_out` and `zero` into the `rsp_*` registers, set `rsp_valid<=1`, and go to RESP.
- RESP:
  - Hold all `rsp_*` outputs stable until `rsp_valid && rsp_ready`.
  - On that handshake, clear `rsp_valid` and go to IDLE.
- `req_ready` is zero in EXEC and RESP. Requesters keep their payload stable while valid and not yet accepted.
- ALU arithmetic (4-bit, results mod 16):
  - add: `carry` is bit 4 of a+b.
  - sub: `result` is a-b mod 16; `carry` is the carry-out of a + ((~b+1) mod 16). That equals (a>=b) for b≠0 and is 0 for b=0.
  - and / or: `carry` is 0.
  - `zero` is 1 when `result` is 0, for every op.
- Round-robin is fair: a requester that holds valid continuously is granted within NUM_REQ grants.
- Bits of `req_valid` at index NUM_REQ or above do not exist. `rsp_id` is zero-extended to 2 bits.

## Timing
- While `rst` is high at an edge:
  - State goes to IDLE and `last_grant` to NUM_REQ-1, so requester 0 wins first.
  - `rsp_valid`, `rsp_result`, `rsp_carry`, `rsp_zero`, `rsp_id` and `busy` go to 0.
  - `req_ready` is 0 throughout the reset cycle.
- Reset mid-operation (EXEC or RESP) drops the in-flight operation with no response. Its requester was already acknowledged and is not re-granted for it.
- Latency: accept in cycle N, EXEC in N+1, `rsp_valid` high from N+2.
- If `rsp_ready` is high in cycle N+2, the response completes that cycle, the block is IDLE in N+3, and the next grant can occur in N+3. Peak throughput is one operation per 3 cycles.
- A requester that drops `req_valid` in the same cycle it is granted is still accepted, because the grant depends on the current-cycle valid.
- `rsp_ready` asserted while `rsp_valid` is low has no effect.

## Test plan
- Single request: req0 sends a=3, b=5, sel=00. Expect `req_ready[0]` for exactly 1 cycle, then `rsp_valid` 2 cycles later with result=8, carry=0, zero=0, id=0.
- Sub corners:
  - a=5, b=5, sel=01 → result=0, carry=1, zero=1.
  - a=3, b=0, sel=01 → result=3, carry=0.
  - a=2, b=3, sel=01 → result=15, carry=0.
- Add overflow and logic ops:
  - a=15, b=1, sel=00 → result=0, carry=1, zero=1.
  - a=12, b=10, sel=10 → 8.
  - sel=11 → 14, carry=0.
- Fairness: all four requesters hold valid continuously with `rsp_ready`=1. Grants go 0,1,2,3,0,1 with one grant every 3 cycles, and `rsp_id` follows the same sequence.
- Backpressure: `rsp_ready` held low for 5 cycles. `rsp_*` stay stable, `busy`=1, `req_ready` stays 0. The response completes on the first cycle `rsp_ready` is high, and the next grant comes one cycle later.
- Reset in EXEC: pulse `rst` for 1 cycle after granting req2. Expect no `rsp_valid`, all outputs at 0, and the next grant goes to req0 even with req1..3 valid.
